// File: rtl/keypad_pw_encoder.sv
// keypad_pw_encoder
//   Scans a 4x4 active-low matrix keypad, debounces one key at a time and
//   presents it to the password checker as a digit/strobe pair.
//
// Ports
//   clk          system clock, everything on the rising edge
//   rst_a        synchronous reset, active-high
//   col_in[3:0]  keypad columns, active-low, asynchronous to clk
//   row_out[3:0] keypad rows, active-low, exactly one bit low at all times
//   entrada_pw   code of the debounced key = row*4 + col (upper bits 0)
//   enable_data  high while a debounced key is held
//   state_dbg    current FSM state (SCAN=0, DEBOUNCE=1, PRESSED=2, RELEASE=3)
//
// Interface to the password checker:
//   enable_data is a level "valid" with no ready/back-pressure. While it is
//   high, entrada_pw is stable. One rising edge of enable_data means exactly
//   one key press; entrada_pw only changes on that rising edge and otherwise
//   holds the last key.
module keypad_pw_encoder #(
  parameter int Bits         = 4,
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 50000
) (
  input  logic            clk,
  input  logic            rst_a,
  input  logic [3:0]      col_in,
  output logic [3:0]      row_out,
  output logic [Bits-1:0] entrada_pw,
  output logic            enable_data,
  output logic [1:0]      state_dbg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  logic [1:0]        state;
  logic [1:0]        row_idx;
  logic [1:0]        key_row;
  logic [1:0]        key_col;
  logic [SCAN_W-1:0] scan_cnt;
  logic [DEB_W-1:0]  deb_cnt;
  logic [3:0]        col_meta;
  logic [3:0]        col_s;
  logic [1:0]        low_col;
  logic [3:0]        key_code;

  // Two-flop synchronizer. Resetting to all-high (no key) means a key held
  // through reset looks like a brand-new press and needs a full debounce.
  always_ff @(posedge clk) begin
    if (rst_a) begin
      col_meta <= 4'hF;
      col_s    <= 4'hF;
    end else begin
      col_meta <= col_in;
      col_s    <= col_meta;
    end
  end

  // Lowest-index low column wins when several keys in one row are down.
  always_comb begin
    low_col = 2'd3;
    if (!col_s[0])      low_col = 2'd0;
    else if (!col_s[1]) low_col = 2'd1;
    else if (!col_s[2]) low_col = 2'd2;
    else                low_col = 2'd3;
  end

  assign key_code  = {key_row, key_col};
  assign row_out   = ~(4'b0001 << row_idx);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state       <= ST_SCAN;
      row_idx     <= 2'd0;
      key_row     <= 2'd0;
      key_col     <= 2'd0;
      scan_cnt    <= '0;
      deb_cnt     <= '0;
      entrada_pw  <= '0;
      enable_data <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          // Columns are only looked at on the last cycle of a row, by which
          // time the synchronizer has flushed anything from the previous row.
          if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            if (col_s == 4'hF) begin
              row_idx <= row_idx + 2'd1;
            end else begin
              key_row <= row_idx;
              key_col <= low_col;
              deb_cnt <= '0;
              state   <= ST_DEBOUNCE;
            end
          end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
          end
        end

        ST_DEBOUNCE: begin
          if (!col_s[key_col]) begin
            if (deb_cnt == DEB_LAST) begin
              state       <= ST_PRESSED;
              entrada_pw  <= Bits'(key_code);
              enable_data <= 1'b1;
              deb_cnt     <= '0;
            end else begin
              deb_cnt <= deb_cnt + DEB_W'(1);
            end
          end else begin
            // Bounce or glitch: rescan the same row from the start.
            state    <= ST_SCAN;
            scan_cnt <= '0;
            deb_cnt  <= '0;
          end
        end

        ST_PRESSED: begin
          // Only the captured column matters; other keys are ignored.
          if (col_s[key_col]) begin
            enable_data <= 1'b0;
            deb_cnt     <= '0;
            state       <= ST_RELEASE;
          end
        end

        ST_RELEASE: begin
          // No path back to PRESSED from here, so release bounce can never
          // produce a second strobe.
          if (col_s != 4'hF) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state    <= ST_SCAN;
            row_idx  <= row_idx + 2'd1;
            scan_cnt <= '0;
            deb_cnt  <= '0;
          end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
          end
        end

        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_pw_encoder.sv
// Bench for keypad_pw_encoder with SCAN_DIV=4, DEBOUNCE_CNT=8, Bits=6.
// A key-matrix model pulls a column low only while its row is driven.
// Note: a key held through reset is re-detected after a full debounce once
// scanning reaches its row again; this is accepted behaviour and is checked.
module tb_keypad_pw_encoder;

  localparam int BITS     = 6;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  // ---------------- clock / reset ----------------
  logic            clk   = 1'b0;
  logic            rst_a = 1'b1;
  logic [3:0]      col_in;
  logic [3:0]      row_out;
  logic [BITS-1:0] entrada_pw;
  logic            enable_data;
  logic [1:0]      state_dbg;
  logic [15:0]     keys = 16'h0000;

  always #5 clk = ~clk;

  keypad_pw_encoder #(
    .Bits(BITS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)
  ) dut (
    .clk(clk), .rst_a(rst_a), .col_in(col_in), .row_out(row_out),
    .entrada_pw(entrada_pw), .enable_data(enable_data), .state_dbg(state_dbg)
  );

  // Key matrix: key r*4+c connects row r to column c.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !row_out[r]) col_in[c] = 1'b0;
  end

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic logic [3:0] pat(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << r);
  endfunction

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         pulses = 0;
  logic       en_prev = 1'b0;
  logic [3:0] hist[4];

  always @(negedge clk) begin
    if (enable_data === 1'b1 && en_prev == 1'b0) begin
      pulses++;
      hist[0] = hist[1]; hist[1] = hist[2]; hist[2] = hist[3];
      hist[3] = entrada_pw[3:0];
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_strobe actual=%0d expected=none", entrada_pw);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        check("strobe_code", 32'(entrada_pw), 32'(e));
      end
    end
    en_prev = (enable_data === 1'b1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_row_entry(input int r);
    logic [3:0] prev;
    int ok;
    prev = row_out;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (row_out == pat(r) && prev != pat(r)) begin
        ok = 1;
        break;
      end
      prev = row_out;
    end
    check("row_entry", ok, 1);
  endtask

  typedef struct {
    logic [15:0] keys;
    logic [15:0] extra;
    int          row;
    logic [3:0]  code;
    int          next_row;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    int n;
    int stable;
    wait_row_entry(v.row);
    keys = v.keys;
    exp_q.push_back(v.code);
    n = 0;
    while (!enable_data && n < 100) begin @(negedge clk); n++; end
    check("press_latency", n, 12);
    check("press_code", 32'(entrada_pw), 32'(v.code));
    check("press_row_frozen", 32'(row_out), 32'(pat(v.row)));
    keys = v.keys | v.extra;
    stable = 1;
    repeat (20) begin
      @(negedge clk);
      if (!enable_data || entrada_pw != BITS'(v.code) || row_out != pat(v.row)) stable = 0;
    end
    check("hold_stable", stable, 1);
    keys = 16'h0000;
    n = 0;
    while (enable_data && n < 50) begin @(negedge clk); n++; end
    check("release_latency", n, 3);
    n = 0;
    while (row_out == pat(v.row) && n < 50) begin @(negedge clk); n++; end
    check("rescan_delay", n, 8);
    check("next_row", 32'(row_out), 32'(pat(v.next_row)));
    check("code_held", 32'(entrada_pw), 32'(v.code));
    repeat (60) @(negedge clk);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int n;
    int p0;
    int saw_deb;
    logic pw_pass;

    vecs[0] = '{keys: 16'h0040, extra: 16'h0010, row: 1, code: 4'd6,  next_row: 2};
    vecs[1] = '{keys: 16'h0200, extra: 16'h0000, row: 2, code: 4'd9,  next_row: 3};
    vecs[2] = '{keys: 16'h0100, extra: 16'h0000, row: 2, code: 4'd8,  next_row: 3};
    vecs[3] = '{keys: 16'h0080, extra: 16'h0000, row: 1, code: 4'd7,  next_row: 2};
    vecs[4] = '{keys: 16'h8000, extra: 16'h0000, row: 3, code: 4'd15, next_row: 0};
    vecs[5] = '{keys: 16'h0008, extra: 16'h0000, row: 0, code: 4'd3,  next_row: 1};
    vecs[6] = '{keys: 16'h0A00, extra: 16'h0000, row: 2, code: 4'd9,  next_row: 3};
    vecs[7] = '{keys: 16'h4010, extra: 16'h0000, row: 1, code: 4'd4,  next_row: 2};
    for (int i = 0; i < 4; i++) hist[i] = 4'd0;

    // Reset values and idle scan
    rst_a = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_row_out", 32'(row_out), 32'(4'b1110));
    check("rst_enable", 32'(enable_data), 0);
    check("rst_entrada", 32'(entrada_pw), 0);
    check("rst_state", 32'(state_dbg), 0);
    rst_a = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check("idle_scan", 32'(row_out), 32'(pat((k / 4) % 4)));
    end

    // Password sequence 6, 9, 8, 7
    for (int i = 0; i < 4; i++) run_vec(vecs[i]);
    pw_pass = (hist[0] == 4'd6 && hist[1] == 4'd9 && hist[2] == 4'd8 && hist[3] == 4'd7);
    check("pw_pass", 32'(pw_pass), 1);

    // Wrap, row 0, same-row and cross-row priority
    for (int i = 4; i < 8; i++) run_vec(vecs[i]);

    // Press bounce then release bounce on r1c2
    p0 = pulses;
    exp_q.push_back(4'd6);
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      repeat (3) @(negedge clk);
    end
    keys = 16'h0040;
    n = 0;
    while (!enable_data && n < 100) begin @(negedge clk); n++; end
    check("bounce_pressed", 32'(enable_data), 1);
    check("bounce_code", 32'(entrada_pw), 6);
    for (int i = 0; i < 5; i++) begin
      keys = 16'h0000; repeat (3) @(negedge clk);
      keys = 16'h0040; repeat (3) @(negedge clk);
    end
    keys = 16'h0000;
    repeat (40) @(negedge clk);
    check("bounce_single_pulse", pulses - p0, 1);
    check("bounce_enable_low", 32'(enable_data), 0);
    check("bounce_back_to_scan", 32'(state_dbg), 0);

    // Glitch on r0c0, 5 clks only
    p0 = pulses;
    wait_row_entry(0);
    keys = 16'h0001;
    saw_deb = 0;
    n = 0;
    repeat (5) begin
      @(negedge clk); n++;
      if (state_dbg == 2'd1) saw_deb = 1;
    end
    keys = 16'h0000;
    while (row_out == pat(0) && n < 50) begin
      @(negedge clk); n++;
      if (state_dbg == 2'd1) saw_deb = 1;
    end
    check("glitch_seen", saw_deb, 1);
    check("glitch_rescan_row0", n, 12);
    check("glitch_next_row", 32'(row_out), 32'(pat(1)));
    check("glitch_no_pulse", pulses - p0, 0);

    // Reset while PRESSED on r3c0, key kept held through reset
    wait_row_entry(3);
    keys = 16'h1000;
    exp_q.push_back(4'd12);
    n = 0;
    while (!enable_data && n < 100) begin @(negedge clk); n++; end
    check("pre_rst_pressed", 32'(enable_data), 1);
    p0 = pulses;
    rst_a = 1'b1;
    @(negedge clk);
    check("mid_rst_enable", 32'(enable_data), 0);
    check("mid_rst_row_out", 32'(row_out), 32'(4'b1110));
    check("mid_rst_entrada", 32'(entrada_pw), 0);
    check("mid_rst_state", 32'(state_dbg), 0);
    rst_a = 1'b0;
    exp_q.push_back(4'd12);
    n = 0;
    while (!enable_data && n < 100) begin @(negedge clk); n++; end
    check("held_key_redetect", n, 24);
    check("held_key_one_pulse", pulses - p0, 1);
    keys = 16'h0000;
    repeat (40) @(negedge clk);

    check("exp_q_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
